stack_mask_sequencer: RTL and testbench

//  Turns one decoded push/pop bitmask pair into a serial stack bus transaction stream.

---
 rtl/stack_mask_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stack_mask_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_mask_sequencer.sv
// stack_mask_sequencer
//   Serialises one decoded pop/push bitmask pair into a stream of single-word
//   stack bus requests and keeps a running SP. Pops are issued first, highest
//   set bit first. Pushes follow, lowest set bit first.
//
// Ports
//   clk, reset             core clock, synchronous active-high reset
//   start                  launch a job (honoured only in IDLE)
//   push_mask, pop_mask    slot masks, latched with start
//   sp_in                  SP at launch, latched with start
//   flush                  abandon the current job
//   busy, done             job in progress / one-cycle completion pulse
//   req_valid/req_ready    request handshake to the bus unit
//   req_write              1 = push (write), 0 = pop (read)
//   req_addr, req_index    SS-relative offset and mask bit of the request
//   sp_out                 running SP, final value valid with done
module stack_mask_sequencer #(
  parameter int MASK_W = 16,
  parameter int ADDR_W = 16,
  parameter int STEP   = 2,
  localparam int IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MASK_W-1:0] push_mask,
  input  logic [MASK_W-1:0] pop_mask,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [IDX_W-1:0]  req_index,
  output logic [ADDR_W-1:0] sp_out
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_PUSH, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [MASK_W-1:0] push_q, push_d;
  logic [MASK_W-1:0] pop_q, pop_d;
  logic [ADDR_W-1:0] sp_q, sp_d;

  logic [IDX_W-1:0]  pop_idx, push_idx;
  logic [MASK_W-1:0] pop_rest, push_rest;
  logic              accept;

  // Highest set pop bit: later (higher) iterations overwrite earlier ones.
  always_comb begin
    pop_idx = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (pop_q[i]) pop_idx = IDX_W'(i);
    end
  end

  // Lowest set push bit: scan downwards so the lowest index wins.
  always_comb begin
    push_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (push_q[i]) push_idx = IDX_W'(i);
    end
  end

  // Masks with the bit currently on the bus removed.
  always_comb begin
    pop_rest           = pop_q;
    pop_rest[pop_idx]  = 1'b0;
    push_rest          = push_q;
    push_rest[push_idx] = 1'b0;
  end

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      push_q  <= '0;
      pop_q   <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      sp_q    <= sp_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    push_d  = push_q;
    pop_d   = pop_q;
    sp_d    = sp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          push_d = push_mask;
          pop_d  = pop_mask;
          sp_d   = sp_in;
          if (pop_mask != '0)       state_d = S_POP;
          else if (push_mask != '0) state_d = S_PUSH;
          else                      state_d = S_FIN;
        end
      end
      S_POP: begin
        if (accept) begin
          pop_d = pop_rest;
          sp_d  = sp_q + STEP_A;
          if (pop_rest == '0) state_d = (push_q != '0) ? S_PUSH : S_FIN;
        end
      end
      S_PUSH: begin
        if (accept) begin
          push_d = push_rest;
          sp_d   = sp_q - STEP_A;
          if (push_rest == '0) state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides the transition but keeps any SP change from a
    // transfer accepted in the same cycle.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      push_d  = '0;
      pop_d   = '0;
    end
  end

  // Outputs are a pure function of the registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_index = '0;
    case (state_q)
      S_POP: begin
        req_valid = 1'b1;
        req_addr  = sp_q;
        req_index = pop_idx;
      end
      S_PUSH: begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = sp_q - STEP_A;
        req_index = push_idx;
      end
      default: ;
    endcase
  end

  assign sp_out = sp_q;

endmodule

// File: tb/tb_stack_mask_sequencer.sv
module tb_stack_mask_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] push_mask, pop_mask, sp_in;
  logic        flush;
  logic        busy, done, req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [3:0]  req_index;
  logic [15:0] sp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_mask_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .push_mask(push_mask),
    .pop_mask(pop_mask), .sp_in(sp_in), .flush(flush), .busy(busy),
    .done(done), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_index(req_index),
    .sp_out(sp_out)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [3:0]  i;
  } exp_t;

  typedef struct {
    logic [15:0] pm, qm, sp;
    int          n;
    logic [15:0] sp_f;
    logic        w0;
    logic [15:0] a0;
    logic [3:0]  i0;
  } vec_t;

  vec_t vt[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Runs one job from IDLE. The expected request list is derived directly
  // from the mask rules; every cycle the DUT must present the head of that list.
  task automatic run_job(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp,
                         input int stall, input bit rnd_ready, input bit hold_start,
                         output int n_acc, output logic f_w, output logic [15:0] f_a,
                         output logic [3:0] f_i, output logic [15:0] sp_fin,
                         output int done_cyc, output int valid_cyc);
    exp_t        q[$];
    logic [15:0] s;
    logic        rdy;
    int          st;
    s = sp;
    for (int i = 15; i >= 0; i--) if (qm[i]) begin q.push_back('{1'b0, s, 4'(i)}); s = s + 16'd2; end
    for (int i = 0; i < 16; i++) if (pm[i]) begin s = s - 16'd2; q.push_back('{1'b1, s, 4'(i)}); end
    st = stall;
    n_acc = 0; done_cyc = -1; valid_cyc = 0; f_w = 0; f_a = 0; f_i = 0; sp_fin = 0;
    start = 1; push_mask = pm; pop_mask = qm; sp_in = sp; req_ready = 0;
    tick;
    start = hold_start;
    push_mask = 16'($urandom); pop_mask = 16'($urandom); sp_in = 16'($urandom);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      checks++;
      if (req_valid !== (q.size() != 0) || done !== (q.size() == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL job_ctrl cyc=%0d: valid=%b done=%b busy=%b, expected valid=%b done=%b busy=1",
                 cyc, req_valid, done, busy, q.size() != 0, q.size() == 0);
      end
      if (req_valid && q.size() != 0) begin
        checks++;
        if (req_write !== q[0].w || req_addr !== q[0].a || req_index !== q[0].i) begin
          errors++;
          $display("FAIL req_fields cyc=%0d: w=%b a=%h i=%0d, expected w=%b a=%h i=%0d",
                   cyc, req_write, req_addr, req_index, q[0].w, q[0].a, q[0].i);
        end
      end
      if (done || q.size() == 0) begin
        sp_fin = sp_out;
        if (done) done_cyc = cyc;
        break;
      end
      if (st > 0) rdy = 1'b0;
      else rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req_valid) begin
        valid_cyc++;
        if (st > 0) st--;
      end
      req_ready = rdy;
      if (req_valid && rdy) begin
        if (n_acc == 0) begin f_w = req_write; f_a = req_addr; f_i = req_index; end
        n_acc++;
        void'(q.pop_front());
      end
      tick;
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL job_timeout: no done seen, %0d requests left", q.size());
    end
    chk("job_sp_final", sp_fin, s);
    // start may still be high during FIN; it must be ignored.
    req_ready = 0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || req_valid !== 1'b0 || sp_out !== sp_fin) begin
      errors++;
      $display("FAIL after_done: busy=%b done=%b valid=%b sp=%h, expected 0 0 0 sp=%h",
               busy, done, req_valid, sp_out, sp_fin);
    end
    start = 0;
  endtask

  initial begin
    int          n, dc, vc;
    logic        fw;
    logic [15:0] fa, spf;
    logic [3:0]  fi;
    bit          nodone;

    vt[0] = '{16'h0003, 16'h0000, 16'h0100, 2,  16'h00FC, 1'b1, 16'h00FE, 4'd0};
    vt[1] = '{16'h0000, 16'h2400, 16'h00FC, 2,  16'h0100, 1'b0, 16'h00FC, 4'd13};
    vt[2] = '{16'h0002, 16'h0001, 16'hFFFE, 2,  16'hFFFE, 1'b0, 16'hFFFE, 4'd0};
    vt[3] = '{16'h0000, 16'h0000, 16'h1234, 0,  16'h1234, 1'b0, 16'h0000, 4'd0};
    vt[4] = '{16'h8001, 16'h8001, 16'h0000, 4,  16'h0000, 1'b0, 16'h0000, 4'd15};
    vt[5] = '{16'hFFFF, 16'h0000, 16'h0010, 16, 16'hFFF0, 1'b1, 16'h000E, 4'd0};

    reset = 1; start = 0; push_mask = 0; pop_mask = 0; sp_in = 0; flush = 0; req_ready = 0;
    tick; tick;
    chk("reset_outputs", {busy, done, req_valid, req_write, req_addr, req_index, sp_out},
        {4'b0, 16'h0, 4'h0, 16'h0});
    reset = 0;
    tick;

    // Directed table, ready always high.
    for (int k = 0; k < 6; k++) begin
      run_job(vt[k].pm, vt[k].qm, vt[k].sp, 0, 0, 0, n, fw, fa, fi, spf, dc, vc);
      chk($sformatf("vec%0d_count", k), n, vt[k].n);
      chk($sformatf("vec%0d_sp", k), spf, vt[k].sp_f);
      chk($sformatf("vec%0d_done_cycle", k), dc, vt[k].n + 1);
      if (vt[k].n > 0) chk($sformatf("vec%0d_first", k), {fw, fa, fi}, {vt[k].w0, vt[k].a0, vt[k].i0});
      $display("vec%0d push=%h pop=%h sp_in=%h -> accepts=%0d sp_out=%h done@%0d", k,
               vt[k].pm, vt[k].qm, vt[k].sp, n, spf, dc);
    end

    // Ready held low for the first 3 cycles of a single push.
    run_job(16'h0001, 16'h0000, 16'h0100, 3, 0, 0, n, fw, fa, fi, spf, dc, vc);
    chk("stall_valid_cycles", vc, 4);
    chk("stall_done_cycle", dc, 5);
    chk("stall_first", {fw, fa, fi}, {1'b1, 16'h00FE, 4'd0});
    $display("stall job: valid cycles=%0d done@%0d", vc, dc);

    // start kept asserted with junk masks throughout the job and FIN.
    run_job(16'h0003, 16'h0000, 16'h0100, 0, 0, 1, n, fw, fa, fi, spf, dc, vc);
    chk("busy_start_count", n, 2);
    $display("start-while-busy job: accepts=%0d sp_out=%h", n, spf);
    run_job(16'h0000, 16'h0000, 16'hBEEF, 0, 0, 1, n, fw, fa, fi, spf, dc, vc);
    chk("empty_busy_start_sp", spf, 16'hBEEF);

    // Flush on the third accept: that transfer still counts.
    start = 1; push_mask = 16'h00FF; pop_mask = 0; sp_in = 16'h0100; req_ready = 1;
    tick; start = 0;
    tick; tick;
    flush = 1;
    tick; flush = 0;
    chk("flush_state", {busy, done, req_valid}, 3'b000);
    chk("flush_sp", sp_out, 16'h00FA);
    nodone = 1;
    for (int c = 0; c < 4; c++) begin
      if (done || busy || req_valid) nodone = 0;
      tick;
    end
    chk("flush_quiet", nodone, 1'b1);
    $display("flush job: sp_out=%h", sp_out);

    // Same job aborted by reset instead.
    start = 1; push_mask = 16'h00FF; pop_mask = 0; sp_in = 16'h0100; req_ready = 1;
    tick; start = 0;
    tick; tick;
    reset = 1;
    tick;
    chk("midjob_reset", {busy, done, req_valid, req_write, req_addr, req_index, sp_out},
        {4'b0, 16'h0, 4'h0, 16'h0});
    reset = 0; req_ready = 0;
    tick;
    $display("reset mid-job: outputs cleared");

    // Randomised jobs against the mask-rule model.
    for (int r = 0; r < 60; r++) begin
      logic [15:0] pm, qm;
      pm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      qm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_job(pm, qm, 16'($urandom), int'($urandom_range(0, 2)), 1, 1'($urandom_range(0, 1)),
              n, fw, fa, fi, spf, dc, vc);
      $display("rand%0d push=%h pop=%h accepts=%0d sp_out=%h done@%0d", r, pm, qm, n, spf, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
